// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with lane steering, extension, misalignment and timeout detection.
module mem_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [3:0]              mem_op_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [4:0]              rd_add_i,
  output logic                    dmem_req_o,
  input  logic                    dmem_gnt_i,
  output logic                    dmem_we_o,
  output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
  output logic [DATA_WIDTH/8-1:0] dmem_be_o,
  output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
  input  logic                    dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_data_o,
  output logic [4:0]              rsp_rd_add_o,
  output logic                    load_err_o,
  output logic                    store_err_o,
  output logic                    bus_err_o,
  output logic [ADDR_WIDTH-1:0]   last_add_o
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, next;
  logic is_load, is_store, bad, accept, timeout, sgn_q, st_q;
  logic [1:0] sz, sz_q;
  logic [NB-1:0] mask;
  logic [OW-1:0] off, off_q;
  logic [4:0] rd_q;
  logic [7:0] cnt;
  logic [DATA_WIDTH-1:0] sh, ext_b, ext_h, ext_w, ld_data;
  assign is_load = mem_op_i >= 4'd1 && mem_op_i <= 4'd7;
  assign is_store = mem_op_i >= 4'd8 && mem_op_i <= 4'd11;
  assign sz = (mem_op_i == 4'd1 || mem_op_i == 4'd4 || mem_op_i == 4'd8) ? 2'd0 :
              (mem_op_i == 4'd2 || mem_op_i == 4'd5 || mem_op_i == 4'd9) ? 2'd1 :
              (mem_op_i == 4'd3 || mem_op_i == 4'd6 || mem_op_i == 4'd10) ? 2'd2 : 2'd3;
  // Doubleword and LWU only exist on a 64-bit bus.
  assign bad = (sz == 2'd1 && addr_i[0]) || (sz == 2'd2 && |addr_i[1:0]) ||
               (sz == 2'd3 && |addr_i[2:0]) || (NB == 4 && (sz == 2'd3 || mem_op_i == 4'd6));
  assign mask = sz == 2'd0 ? NB'(1) : sz == 2'd1 ? NB'(3) : sz == 2'd2 ? NB'(15) : '1;
  assign off = addr_i[OW-1:0];
  assign accept = state == IDLE && req_valid_i && (is_load || is_store);
  assign timeout = cnt == 8'(TIMEOUT);
  assign req_ready_o = state == IDLE;
  assign dmem_req_o = state == REQ;
  assign sh = dmem_rdata_i >> {off_q, 3'b000};
  assign ext_b = sgn_q ? DATA_WIDTH'($signed(sh[7:0])) : DATA_WIDTH'(sh[7:0]);
  assign ext_h = sgn_q ? DATA_WIDTH'($signed(sh[15:0])) : DATA_WIDTH'(sh[15:0]);
  assign ext_w = sgn_q ? DATA_WIDTH'($signed(sh[31:0])) : DATA_WIDTH'(sh[31:0]);
  assign ld_data = st_q ? '0 : sz_q == 2'd0 ? ext_b : sz_q == 2'd1 ? ext_h : sz_q == 2'd2 ? ext_w : sh;
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = (accept && !bad) ? REQ : IDLE;
      REQ: next = dmem_gnt_i ? WAIT : REQ;
      WAIT: next = (dmem_rvalid_i || timeout) ? IDLE : WAIT;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_o <= 1'b0;
      load_err_o <= 1'b0;
      store_err_o <= 1'b0;
      bus_err_o <= 1'b0;
      rsp_data_o <= '0;
      rsp_rd_add_o <= '0;
      last_add_o <= '0;
      dmem_we_o <= 1'b0;
      dmem_addr_o <= '0;
      dmem_be_o <= '0;
      dmem_wdata_o <= '0;
      off_q <= '0;
      sz_q <= '0;
      sgn_q <= 1'b0;
      st_q <= 1'b0;
      rd_q <= '0;
      cnt <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      load_err_o <= 1'b0;
      store_err_o <= 1'b0;
      bus_err_o <= 1'b0;
      if (accept) begin
        last_add_o <= addr_i;
        off_q <= off;
        sz_q <= sz;
        sgn_q <= mem_op_i inside {4'd1, 4'd2, 4'd3, 4'd7};
        st_q <= is_store;
        rd_q <= rd_add_i;
        cnt <= '0;
        if (bad) begin
          rsp_valid_o <= 1'b1;
          load_err_o <= is_load;
          store_err_o <= is_store;
          rsp_data_o <= '0;
          rsp_rd_add_o <= rd_add_i;
        end else begin
          dmem_we_o <= is_store;
          dmem_addr_o <= {addr_i[ADDR_WIDTH-1:OW], OW'(0)};
          dmem_be_o <= is_store ? mask << off : '0;
          dmem_wdata_o <= wdata_i << {off, 3'b000};
        end
      end
      if (state == WAIT) begin
        if (dmem_rvalid_i || timeout) begin
          rsp_valid_o <= 1'b1;
          bus_err_o <= !dmem_rvalid_i;
          rsp_data_o <= dmem_rvalid_i ? ld_data : '0;
          rsp_rd_add_o <= rd_q;
        end else cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised load/store unit for the MEM stage of the 5-stage pipeline: accepts one memory operation at a time from EX/MEM over a valid/ready handshake and drives a request/grant/response data-memory port with variable latency. It supports 32- or 64-bit data buses and performs byte-lane steering plus sign/zero extension. It detects misaligned accesses and memory timeouts, and returns a single registered response to the writeback path.

## Interface
- DATA_WIDTH, 32, data bus width; legal values 32 or 64; NB = DATA_WIDTH/8 byte lanes.
- ADDR_WIDTH, 32, byte-address width.
- TIMEOUT, 255, maximum cycles in WAIT without dmem_rvalid_i before bus error; 8-bit counter.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  operation request from pipeline.
- req_ready_o  out  1  high only in IDLE.
- mem_op_i  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 LWU, 7 LD, 8 SB, 9 SH, 10 SW, 11 SD, 12-15 treated as NONE.
- addr_i  in  ADDR_WIDTH  byte address.
- wdata_i  in  DATA_WIDTH  store data, least-significant bytes used.
- rd_add_i  in  5  destination register, echoed on response.
- dmem_req_o  out  1  memory request, held until grant.
- dmem_gnt_i  in  1  memory accepts request.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  ADDR_WIDTH  addr with low log2(NB) bits zeroed.
- dmem_be_o  out  NB  byte enables (zero for loads).
- dmem_wdata_o  out  DATA_WIDTH  lane-steered store data.
- dmem_rvalid_i  in  1  response/ack from memory.
- dmem_rdata_i  in  DATA_WIDTH  read data.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_data_o  out  DATA_WIDTH  extended load result; 0 for stores/errors.
- rsp_rd_add_o  out  5  echoed rd_add_i.
- load_err_o, store_err_o  out  1  misalignment/illegal-width error, valid with rsp_valid_o.
- bus_err_o  out  1  timeout error, valid with rsp_valid_o.
- last_add_o  out  ADDR_WIDTH  unaligned address of the most recently accepted operation.

## Operation
- FSM: IDLE, REQ, WAIT. Accept when req_valid_i && req_ready_o && op not NONE; NONE ops are consumed with no effect.
- On accept: latch op, addr, rd_add, last_add_o; compute off = addr[log2(NB)-1:0].
- Alignment: H needs addr[0]=0; W/WU needs addr[1:0]=0; D needs addr[2:0]=0. D/WU ops are illegal when DATA_WIDTH=32. On misaligned or illegal op: stay IDLE, issue no memory access, and pulse rsp_valid_o next cycle with load_err_o (loads) or store_err_o (stores) set.
- Legal op: go REQ. dmem_be_o = size-mask << off (stores). dmem_wdata_o = wdata_i << 8*off. All dmem outputs are registered and stable while in REQ.
- REQ: dmem_req_o=1. On dmem_gnt_i, go WAIT and deassert dmem_req_o.
- WAIT: count cycles. On dmem_rvalid_i: rsp_data_o = (dmem_rdata_i >> 8*off) truncated to size, sign-extended (LB/LH/LW/LD) or zero-extended (LBU/LHU/LWU); stores return 0. Then pulse rsp_valid_o and go IDLE. If count reaches TIMEOUT first, pulse rsp_valid_o with bus_err_o=1 and data 0, then go IDLE.
- dmem_rvalid_i is ignored outside WAIT, and in the grant cycle.

## Timing
- Reset: state IDLE; all outputs 0 except req_ready_o=1 from the first post-reset cycle. Reset during REQ/WAIT abandons the transaction, drops dmem_req_o next edge, and produces no response.
- Zero-wait path: accept at N, dmem_req_o at N+1, gnt at N+1, rvalid at N+2, rsp_valid_o at N+3. req_ready_o is high again at N+3.
- Error path: accept at N, rsp_valid_o with error at N+1, ready throughout.
- rsp_valid_o and all error flags are single-cycle pulses. rsp_data_o/rsp_rd_add_o hold their value until the next response.
- Timeout: bus_err response arrives exactly TIMEOUT+1 cycles after entering WAIT.

## Test plan
- DATA_WIDTH=32, SB addr 0x103, wdata 0xAB -> dmem_addr_o 0x100, be 4'b1000, wdata 0xAB000000, we=1; rvalid -> rsp_valid_o, data 0.
- LB addr 0x102, rdata 0x00F00000 -> rsp_data_o 0xFFFFFFF0; same with LBU -> 0x000000F0.
- LW addr 0x202 -> no dmem_req_o, load_err_o pulse at N+1, last_add_o 0x202; SH addr 0x1 -> store_err_o.
- DATA_WIDTH=64, LD addr 0x8, rdata 0x8000_0000_0000_0001 -> rsp_data_o unchanged, be 0; LWU addr 0xC, rdata 0xFFFF_FFFF_0000_0000 -> 0x0000_0000_FFFF_FFFF.
- Grant delayed 3 cycles, rvalid 5 cycles later -> dmem_req_o/addr held stable 4 cycles, single rsp_valid_o, req_ready_o low throughout.
- TIMEOUT=4, no rvalid -> bus_err_o at 5th WAIT cycle; assert rst mid-WAIT -> no response, dmem_req_o 0, req_ready_o 1 next cycle.
